// File: rtl/multichannel_clock_divider.sv
// Bank of independent glitch-free programmable clock dividers with per-channel pending update.
// Optional MULTICHANNEL_CLOCK_DIVIDER_DUTY_CORRECTION_EN gives 50% duty for odd divisions.
module multichannel_clock_divider #(
    parameter int CHANNELS       = 4,
    parameter int DIVISION_WIDTH = 4,
    parameter int RESET_DIVISION = 2,
    localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                               clock_in,
    input  logic                               reset,
    input  logic                               update_valid,
    input  logic [CH_W-1:0]                    update_channel,
    input  logic [DIVISION_WIDTH-1:0]          update_division,
    output logic                               update_ready,
    output logic [CHANNELS-1:0]                clock_out,
    output logic [CHANNELS-1:0]                period_start,
    output logic [CHANNELS*DIVISION_WIDTH-1:0] active_division
);
    localparam int DW = DIVISION_WIDTH;
    localparam logic [DW-1:0] RST_DIV = DW'(RESET_DIVISION);

    logic [CHANNELS-1:0] w_pend_sel;

    // An out-of-range channel never matches a slot, so it sees ready and is dropped.
    assign update_ready = ~(|w_pend_sel);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [DW-1:0] r_div;
            logic [DW-1:0] r_count;
            logic [DW-1:0] r_pend_val;
            logic          r_pend;
            logic          r_out;
            logic          r_ps;
            logic          r_gate;
            logic          w_sel;
            logic          w_accept;
            logic          w_idle;
            logic          w_wrap;
            logic          w_apply;
            logic          w_high;
            logic          w_out;
            logic [DW:0]   w_half;

            assign w_sel          = (update_channel == CH_W'(gi));
            assign w_pend_sel[gi] = w_sel & r_pend;
            assign w_accept       = update_valid & w_sel & ~r_pend;
            assign w_idle         = ({1'b0, r_div} < (DW+1)'(2));
            assign w_wrap         = (r_count == (r_div - DW'(1)));
            // Stopped and bypass channels have no period to finish, so they apply at once.
            assign w_apply        = r_pend & (w_idle | w_wrap);
            assign w_half         = ({1'b0, r_div} + (DW+1)'(1)) >> 1;
            assign w_high         = ~w_idle & ({1'b0, r_count} < w_half);

            always_ff @(posedge clock_in) begin
                if (reset) begin
                    r_div      <= RST_DIV;
                    r_count    <= '0;
                    r_pend     <= 1'b0;
                    r_pend_val <= '0;
                    r_out      <= 1'b0;
                    r_ps       <= 1'b0;
                end else begin
                    r_out <= w_high;
                    r_ps  <= (r_div == DW'(1)) | (~w_idle & (r_count == '0));
                    if (w_apply) begin
                        r_div   <= r_pend_val;
                        r_pend  <= 1'b0;
                        r_count <= '0;
                    end else if (w_idle || w_wrap) begin
                        r_count <= '0;
                    end else begin
                        r_count <= r_count + DW'(1);
                    end
                    if (w_accept) begin
                        r_pend     <= 1'b1;
                        r_pend_val <= update_division;
                    end
                end
            end

            // Gate changes only while clock_in is low, so the bypass path cannot glitch.
            always_ff @(negedge clock_in) begin
                if (reset) begin
                    r_gate <= 1'b0;
                end else begin
                    r_gate <= (r_div == DW'(1));
                end
            end

`ifdef MULTICHANNEL_CLOCK_DIVIDER_DUTY_CORRECTION_EN
            logic r_out_neg;
            logic r_odd;

            always_ff @(posedge clock_in) begin
                if (reset) begin
                    r_odd <= 1'b0;
                end else begin
                    r_odd <= r_div[0] & ({1'b0, r_div} >= (DW+1)'(3));
                end
            end

            always_ff @(negedge clock_in) begin
                if (reset) begin
                    r_out_neg <= 1'b0;
                end else begin
                    r_out_neg <= r_out;
                end
            end

            // Odd divisions: rising edge moves half a cycle later, falling edge stays put.
            assign w_out = r_odd ? (r_out & r_out_neg) : r_out;
`else
            assign w_out = r_out;
`endif

            assign clock_out[gi]                   = w_out | (clock_in & r_gate);
            assign period_start[gi]                = r_ps;
            assign active_division[gi*DW +: DW]    = r_div;
        end
    endgenerate
endmodule

// File: tb/tb_multichannel_clock_divider.sv
// Directed self-checking bench for multichannel_clock_divider (4 channels, 4-bit divisions).
module tb_multichannel_clock_divider;
    logic        clk;
    logic        reset;
    logic        update_valid;
    logic [1:0]  update_channel;
    logic [3:0]  update_division;
    logic        update_ready;
    logic [3:0]  clock_out;
    logic [3:0]  period_start;
    logic [15:0] active_division;

    int vectors;
    int miscompares;
    int short_pulses;
    time t_rise;
    bit  rise_seen;

    multichannel_clock_divider #(
        .CHANNELS(4),
        .DIVISION_WIDTH(4),
        .RESET_DIVISION(2)
    ) dut (
        .clock_in(clk),
        .reset(reset),
        .update_valid(update_valid),
        .update_channel(update_channel),
        .update_division(update_division),
        .update_ready(update_ready),
        .clock_out(clock_out),
        .period_start(period_start),
        .active_division(active_division)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // High pulses on channel 2 shorter than half an input period are glitches.
    always @(clock_out[2]) begin
        if (clock_out[2] === 1'b1) begin
            t_rise    = $time;
            rise_seen = 1'b1;
        end else if (rise_seen && ($time - t_rise) < 5) begin
            short_pulses++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_update(input int ch, input int d);
        update_valid    = 1'b1;
        update_channel  = 2'(ch);
        update_division = 4'(d);
        tick();
        update_valid = 1'b0;
    endtask

    task automatic wait_active(input int ch, input int d);
        int n;
        n = 0;
        while (active_division[ch*4 +: 4] !== 4'(d) && n < 40) begin
            tick();
            n++;
        end
        vectors++;
        if (active_division[ch*4 +: 4] !== 4'(d)) begin
            miscompares++;
            $display("FAIL apply_ch%0d: active_division=%0d required %0d (timeout)", ch, active_division[ch*4 +: 4], d);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({clock_out, period_start, update_ready} !== 9'b0000_0000_1) begin
            miscompares++;
            $display("FAIL reset_outputs: clock_out=%b period_start=%b ready=%b required 0000 0000 1", clock_out, period_start, update_ready);
        end
        vectors++;
        if (active_division !== 16'h2222) begin
            miscompares++;
            $display("FAIL reset_active: %h required 2222", active_division);
        end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic [3:0] exp_v;
            tick();
            exp_v = (k % 2 == 0) ? 4'b1111 : 4'b0000;
            vectors++;
            if (clock_out !== exp_v || period_start !== exp_v) begin
                miscompares++;
                $display("FAIL reset_release_c%0d: clock_out=%b period_start=%b required %b", k, clock_out, period_start, exp_v);
            end
        end
    endtask

    task automatic test_sweep;
        for (int d = 0; d < 16; d++) begin
            int err;
            int ps_cnt;
            int hi_cnt;
            int exp_hi;
            int n;
            send_update(0, d);
            wait_active(0, d);
            if (d == 0) begin
                ps_cnt = 0;
                hi_cnt = 0;
                repeat (20) begin
                    ps_cnt += int'(period_start[0]);
                    hi_cnt += int'(clock_out[0]);
                    tick();
                end
                vectors++;
                if (ps_cnt != 0 || hi_cnt != 0) begin
                    miscompares++;
                    $display("FAIL sweep_d0_stopped: edges=%0d high=%0d required 0 0", ps_cnt, hi_cnt);
                end
            end else if (d == 1) begin
                err = 0;
                tick();
                repeat (6) begin
                    if (clock_out[0] !== 1'b1 || period_start[0] !== 1'b1) err++;
                    @(negedge clk);
                    #1;
                    if (clock_out[0] !== 1'b0) err++;
                    tick();
                end
                vectors++;
                if (err != 0) begin
                    miscompares++;
                    $display("FAIL sweep_d1_bypass: %0d samples differ from clock_in, required 0", err);
                end
            end else begin
                tick();
                n = 0;
                while (period_start[0] !== 1'b1 && n < 40) begin
                    tick();
                    n++;
                end
                ps_cnt = 0;
                hi_cnt = 0;
                for (int i = 0; i < 4 * d; i++) begin
                    ps_cnt += int'(period_start[0]);
                    hi_cnt += int'(clock_out[0]);
                    tick();
                end
`ifdef MULTICHANNEL_CLOCK_DIVIDER_DUTY_CORRECTION_EN
                exp_hi = (d % 2 == 1) ? 4 * ((d - 1) / 2) : 4 * (d / 2);
`else
                exp_hi = 4 * ((d + 1) / 2);
`endif
                vectors++;
                if (ps_cnt != 4 || hi_cnt != exp_hi) begin
                    miscompares++;
                    $display("FAIL sweep_d%0d: periods=%0d high_samples=%0d in %0d cycles, required 4 %0d", d, ps_cnt, hi_cnt, 4 * d, exp_hi);
                end
            end
        end
    endtask

    task automatic test_mid_update;
        logic [11:0] got_out;
        logic [11:0] got_ps;
        logic [11:0] exp_out;
        logic [11:0] exp_ps;
        logic [3:0]  act_c2;
        logic [3:0]  act_c3;
        int n;
`ifdef MULTICHANNEL_CLOCK_DIVIDER_DUTY_CORRECTION_EN
        exp_out = 12'b0000_1110_0011;
`else
        exp_out = 12'b1000_1111_0011;
`endif
        exp_ps = 12'b1000_0001_0001;
        send_update(1, 4);
        wait_active(1, 4);
        tick();
        n = 0;
        while (period_start[1] !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        // c0: first cycle of a 4-cycle period
        got_out[0] = clock_out[1];
        got_ps[0]  = period_start[1];
        update_channel  = 2'd1;
        update_division = 4'd7;
        update_valid    = 1'b1;
        #1;
        vectors++;
        if (update_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_ready_c0: ready=%b required 1", update_ready);
        end
        tick();
        got_out[1] = clock_out[1];
        got_ps[1]  = period_start[1];
        update_division = 4'd5;
        #1;
        vectors++;
        if (update_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_ready_c1: ready=%b required 0", update_ready);
        end
        tick();
        got_out[2] = clock_out[2 - 1];
        got_ps[2]  = period_start[1];
        act_c2     = active_division[7:4];
        vectors++;
        if (update_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_ready_c2: ready=%b required 0", update_ready);
        end
        update_channel  = 2'd3;
        update_division = 4'd6;
        #1;
        vectors++;
        if (update_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL concurrent_ready_ch3: ready=%b required 1", update_ready);
        end
        tick();
        update_valid   = 1'b0;
        update_channel = 2'd1;
        got_out[3] = clock_out[1];
        got_ps[3]  = period_start[1];
        act_c3     = active_division[7:4];
        #1;
        vectors++;
        if (update_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_ready_c3: ready=%b required 1", update_ready);
        end
        for (int k = 4; k < 12; k++) begin
            tick();
            got_out[k] = clock_out[1];
            got_ps[k]  = period_start[1];
        end
        vectors++;
        if (act_c2 !== 4'd4 || act_c3 !== 4'd7) begin
            miscompares++;
            $display("FAIL mid_apply_cycle: active c2=%0d c3=%0d required 4 7", act_c2, act_c3);
        end
        for (int k = 0; k < 12; k++) begin
            vectors++;
            if (got_out[k] !== exp_out[k] || got_ps[k] !== exp_ps[k]) begin
                miscompares++;
                $display("FAIL mid_wave_c%0d: clock_out=%b period_start=%b required %b %b", k, got_out[k], got_ps[k], exp_out[k], exp_ps[k]);
            end
        end
        wait_active(3, 6);
        vectors++;
        if (active_division[7:4] !== 4'd7) begin
            miscompares++;
            $display("FAIL held_request_dropped: ch1 active=%0d required 7", active_division[7:4]);
        end
    endtask

    task automatic test_stop_bypass;
        logic [4:0] got_out;
        logic [4:0] got_ps;
        logic [4:0] exp_out;
        logic [4:0] exp_ps;
        int err;
`ifdef MULTICHANNEL_CLOCK_DIVIDER_DUTY_CORRECTION_EN
        exp_out = 5'b00100;
`else
        exp_out = 5'b10110;
`endif
        exp_ps = 5'b10010;
        short_pulses = 0;
        send_update(2, 0);
        wait_active(2, 0);
        err = 0;
        repeat (5) begin
            if (clock_out[2] !== 1'b0 || period_start[2] !== 1'b0) err++;
            tick();
        end
        vectors++;
        if (err != 0) begin
            miscompares++;
            $display("FAIL stop_ch2_low: %0d active samples, required 0", err);
        end
        send_update(2, 3);
        vectors++;
        if (active_division[11:8] !== 4'd0) begin
            miscompares++;
            $display("FAIL stop_apply_early: active=%0d required 0", active_division[11:8]);
        end
        tick();
        vectors++;
        if (active_division[11:8] !== 4'd3) begin
            miscompares++;
            $display("FAIL stop_apply_next: active=%0d required 3", active_division[11:8]);
        end
        for (int k = 0; k < 5; k++) begin
            got_out[k] = clock_out[2];
            got_ps[k]  = period_start[2];
            tick();
        end
        vectors++;
        if (got_out !== exp_out || got_ps !== exp_ps) begin
            miscompares++;
            $display("FAIL stop_to_div3_wave: clock_out=%b period_start=%b required %b %b", got_out, got_ps, exp_out, exp_ps);
        end
        send_update(2, 1);
        wait_active(2, 1);
        tick();
        err = 0;
        repeat (4) begin
            if (clock_out[2] !== 1'b1 || period_start[2] !== 1'b1) err++;
            @(negedge clk);
            #1;
            if (clock_out[2] !== 1'b0) err++;
            tick();
        end
        vectors++;
        if (err != 0) begin
            miscompares++;
            $display("FAIL ch2_bypass: %0d samples differ from clock_in, required 0", err);
        end
        send_update(2, 0);
        wait_active(2, 0);
        tick();
        err = 0;
        repeat (5) begin
            if (clock_out[2] !== 1'b0 || period_start[2] !== 1'b0) err++;
            @(negedge clk);
            #1;
            if (clock_out[2] !== 1'b0) err++;
            tick();
        end
        vectors++;
        if (err != 0) begin
            miscompares++;
            $display("FAIL ch2_ends_low: %0d high samples, required 0", err);
        end
        vectors++;
        if (short_pulses != 0) begin
            miscompares++;
            $display("FAIL ch2_glitch: %0d short pulses, required 0", short_pulses);
        end
    endtask

    task automatic test_reset_pending;
        int err;
        send_update(1, 9);
        vectors++;
        if (update_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL pending_ready: ready=%b required 0", update_ready);
        end
        reset = 1'b1;
        tick();
        tick();
        vectors++;
        if (active_division !== 16'h2222 || update_ready !== 1'b1 || clock_out !== 4'b0000 || period_start !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_pending_state: active=%h ready=%b clock_out=%b ps=%b required 2222 1 0000 0000", active_division, update_ready, clock_out, period_start);
        end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            logic [3:0] exp_v;
            tick();
            exp_v = (k % 2 == 0) ? 4'b1111 : 4'b0000;
            vectors++;
            if (clock_out !== exp_v || period_start !== exp_v) begin
                miscompares++;
                $display("FAIL restart_c%0d: clock_out=%b period_start=%b required %b", k, clock_out, period_start, exp_v);
            end
        end
        err = 0;
        repeat (20) begin
            if (active_division[7:4] !== 4'd2) err++;
            tick();
        end
        vectors++;
        if (err != 0) begin
            miscompares++;
            $display("FAIL pending_lost: ch1 left division 2 on %0d cycles, required 0", err);
        end
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        short_pulses    = 0;
        rise_seen       = 1'b0;
        t_rise          = 0;
        reset           = 1'b1;
        update_valid    = 1'b0;
        update_channel  = 2'd0;
        update_division = 4'd0;
        test_reset();
        test_sweep();
        test_mid_update();
        test_stop_bypass();
        test_reset_pending();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
